// File: rtl/lcd_rx_pkg.sv
// Shared types and constants for the LCD RGB receive monitor.
// Coordinates are 11 bits wide and saturate rather than wrap.
package lcd_rx_pkg;

  localparam int COORD_W      = 11;
  localparam int H_ACTIVE_DEF = 800;
  localparam int V_ACTIVE_DEF = 480;

  localparam logic [COORD_W-1:0] COORD_MAX = '1;

  typedef enum logic {
    WAIT_FRAME = 1'b0,
    IN_FRAME   = 1'b1
  } rx_state_e;

  function automatic logic [COORD_W-1:0] sat_inc(input logic [COORD_W-1:0] v);
    return (v == COORD_MAX) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/lcd_rx_bound_det.sv
// Edge detection on the registered DE/VS inputs plus the DE-low run counter.
// Pulses are combinational from registered values so they align with stage 1.
module lcd_rx_bound_det
  import lcd_rx_pkg::*;
#(
  parameter bit USE_VS     = 1'b1,
  parameter bit VS_POL     = 1'b0,
  parameter int IDLE_FRAME = 2000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_de,
  input  logic i_vs,
  output logic o_de_rise,
  output logic o_de_fall,
  output logic o_boundary
);

  localparam logic [15:0] IDLE_LAST = 16'(IDLE_FRAME - 1);

  logic        r_de_prev;
  logic        r_vs_prev;
  logic [15:0] r_idle_cnt;
  logic        w_vs_edge;
  logic        w_idle_hit;

  // r_idle_cnt holds the number of consecutive DE-low cycles before the current one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_de_prev  <= 1'b0;
      r_vs_prev  <= 1'b0;
      r_idle_cnt <= '0;
    end else begin
      r_de_prev <= i_de;
      r_vs_prev <= i_vs;
      if (i_de)
        r_idle_cnt <= '0;
      else if (r_idle_cnt != 16'hFFFF)
        r_idle_cnt <= r_idle_cnt + 16'd1;
    end
  end

  assign o_de_rise  = i_de & ~r_de_prev;
  assign o_de_fall  = ~i_de & r_de_prev;
  assign w_vs_edge  = (i_vs == VS_POL) && (r_vs_prev != VS_POL);
  assign w_idle_hit = ~i_de && (r_idle_cnt == IDLE_LAST);
  assign o_boundary = USE_VS ? w_vs_edge : w_idle_hit;

endmodule

// File: rtl/lcd_rx_monitor.sv
// Receive monitor for the LCD RGB parallel interface: re-emits pixels with
// coordinates and measures line/frame geometry against the panel size.
module lcd_rx_monitor
  import lcd_rx_pkg::*;
#(
  parameter int H_ACTIVE   = H_ACTIVE_DEF,
  parameter int V_ACTIVE   = V_ACTIVE_DEF,
  parameter bit USE_VS     = 1'b1,
  parameter bit VS_POL     = 1'b0,
  parameter int IDLE_FRAME = 2000
) (
  input  logic                lcd_clk,
  input  logic                sys_rst_n,
  input  logic                lcd_hs,
  input  logic                lcd_vs,
  input  logic                lcd_de,
  input  logic [23:0]         lcd_rgb,
  output logic                rx_valid,
  output logic [23:0]         rx_data,
  output logic [COORD_W-1:0]  rx_xpos,
  output logic [COORD_W-1:0]  rx_ypos,
  output logic                frame_start,
  output logic [COORD_W-1:0]  line_len,
  output logic [COORD_W-1:0]  frame_lines,
  output logic                err_hlen,
  output logic                err_vlen,
  output logic                locked,
  output logic [15:0]         frame_cnt
);

  localparam logic [COORD_W-1:0] H_LEN = COORD_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0] V_LEN = COORD_W'(V_ACTIVE);

  logic               r_hs_s1;
  logic               r_vs_s1;
  logic               r_de_s1;
  logic [23:0]        r_rgb_s1;
  rx_state_e          r_state;
  logic [COORD_W-1:0] r_x;
  logic [COORD_W-1:0] r_y;
  logic               r_herr;

  logic               w_de_rise;
  logic               w_de_fall;
  logic               w_boundary;
  logic               w_hs_unused;
  logic [COORD_W-1:0] w_x_cur;
  logic               w_line_end;
  logic [COORD_W-1:0] w_line_len;
  logic               w_line_bad;
  logic [COORD_W-1:0] w_y_end;
  logic               w_herr_end;

  lcd_rx_bound_det #(
    .USE_VS     (USE_VS),
    .VS_POL     (VS_POL),
    .IDLE_FRAME (IDLE_FRAME)
  ) u_bound_det (
    .clk        (lcd_clk),
    .rst_n      (sys_rst_n),
    .i_de       (r_de_s1),
    .i_vs       (r_vs_s1),
    .o_de_rise  (w_de_rise),
    .o_de_fall  (w_de_fall),
    .o_boundary (w_boundary)
  );

  assign w_hs_unused = r_hs_s1;

  // A boundary while DE is high closes a partial line (current pixel included),
  // which always counts as a bad line; a same-cycle DE fall is closed first.
  assign w_x_cur    = w_de_rise ? '0 : r_x;
  assign w_line_end = (r_state == IN_FRAME) & (w_de_fall | (w_boundary & r_de_s1));
  assign w_line_len = w_de_fall ? r_x : sat_inc(w_x_cur);
  assign w_line_bad = w_de_fall ? (r_x != H_LEN) : 1'b1;
  assign w_y_end    = w_line_end ? sat_inc(r_y) : r_y;
  assign w_herr_end = r_herr | (w_line_end & w_line_bad);

  always_ff @(posedge lcd_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_hs_s1     <= 1'b0;
      r_vs_s1     <= 1'b0;
      r_de_s1     <= 1'b0;
      r_rgb_s1    <= '0;
      r_state     <= WAIT_FRAME;
      r_x         <= '0;
      r_y         <= '0;
      r_herr      <= 1'b0;
      rx_valid    <= 1'b0;
      rx_data     <= '0;
      rx_xpos     <= '0;
      rx_ypos     <= '0;
      frame_start <= 1'b0;
      line_len    <= '0;
      frame_lines <= '0;
      err_hlen    <= 1'b0;
      err_vlen    <= 1'b0;
      locked      <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      // stage 1: pin capture
      r_hs_s1  <= lcd_hs;
      r_vs_s1  <= lcd_vs;
      r_de_s1  <= lcd_de;
      r_rgb_s1 <= lcd_rgb;
      // stage 2: pixel stream, line and frame bookkeeping
      rx_valid    <= (r_state == IN_FRAME) & r_de_s1;
      rx_data     <= r_rgb_s1;
      rx_xpos     <= w_x_cur;
      rx_ypos     <= r_y;
      frame_start <= w_boundary;
      case (r_state)
        WAIT_FRAME: begin
          if (w_boundary)
            r_state <= IN_FRAME;
        end
        IN_FRAME: begin
          if (r_de_s1)
            r_x <= sat_inc(w_x_cur);
          if (w_line_end) begin
            line_len <= w_line_len;
            r_y      <= w_y_end;
            r_herr   <= w_herr_end;
            r_x      <= '0;
          end
          if (w_boundary) begin
            frame_lines <= w_y_end;
            err_hlen    <= w_herr_end;
            err_vlen    <= (w_y_end != V_LEN);
            locked      <= ~w_herr_end & (w_y_end == V_LEN);
            frame_cnt   <= frame_cnt + 16'd1;
            r_herr      <= 1'b0;
            r_y         <= '0;
            r_x         <= '0;
          end
        end
      endcase
    end
  end

endmodule
